// File: rtl/bus_router.sv
// bus_router: routes one CPU request to a slave channel (boot overlay first, then base/mask decode).
// Latency: slv_req on the accepting edge; cpu_ack one cycle after slv_ack, two after a decode error, TIMEOUT+2 on timeout.
// Backpressure: one transaction in flight; cpu_req is not accepted again until the current one completes.
module bus_router #(
  parameter int                 NSLV       = 4,
  parameter int                 AW         = 24,
  parameter int                 DW         = 16,
  parameter logic [NSLV*AW-1:0] SLV_BASE   = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK   = '0,
  parameter int                 BOOT_SLV   = 0,
  parameter int                 BOOT_LIMIT = 8,
  parameter int                 TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  input  logic [DW/8-1:0]      cpu_wstrb,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic [DW-1:0]        cpu_rdata,
  input  logic                 bootup,
  output logic [NSLV-1:0]      slv_req,
  output logic [AW-1:0]        slv_addr,
  output logic [DW-1:0]        slv_wdata,
  output logic [DW/8-1:0]      slv_wstrb,
  output logic                 slv_we,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic [NSLV*DW-1:0]   slv_rdata,
  output logic [7:0]           err_count
);

  localparam int              SW        = DW / 8;
  localparam int              IW        = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [IW-1:0]   BOOT_IDX  = IW'(BOOT_SLV);
  localparam logic [AW-1:0]   BOOT_MASK = SLV_MASK[BOOT_SLV*AW +: AW];
  localparam logic [AW-1:0]   BOOT_LIM  = AW'(BOOT_LIMIT);
  localparam logic [15:0]     TMO       = 16'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_nxt;
  logic              ack_q, ack_nxt;
  logic              err_q, err_nxt;
  logic [DW-1:0]     rdata_q, rdata_nxt;
  logic [NSLV-1:0]   req_q, req_nxt;
  logic [AW-1:0]     addr_q, addr_nxt;
  logic [DW-1:0]     wdata_q, wdata_nxt;
  logic [SW-1:0]     wstrb_q, wstrb_nxt;
  logic              we_q, we_nxt;
  logic [IW-1:0]     sel_q, sel_nxt;
  logic [15:0]       timer_q, timer_nxt;
  // Decode error seen at acceptance; the error completion is issued on the following edge.
  logic              pend_q, pend_nxt;
  logic [7:0]        errcnt_q, errcnt_nxt;
  logic              err_done;

  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [AW-1:0]     dec_mask;
  logic              sel_ack;
  logic [DW-1:0]     sel_rdata;

  assign sel_ack   = slv_ack[sel_q];
  assign sel_rdata = slv_rdata[sel_q*DW +: DW];

  // Address decode: boot overlay below BOOT_LIMIT, otherwise lowest-index base/mask match.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_mask = '0;
    if (cpu_addr < BOOT_LIM) begin
      if (bootup) begin
        dec_hit  = 1'b1;
        dec_idx  = BOOT_IDX;
        dec_mask = BOOT_MASK;
      end
    end else begin
      for (int i = 0; i < NSLV; i++) begin
        if (!dec_hit &&
            ((cpu_addr & ~SLV_MASK[i*AW +: AW]) ==
             (SLV_BASE[i*AW +: AW] & ~SLV_MASK[i*AW +: AW]))) begin
          dec_hit  = 1'b1;
          dec_idx  = IW'(i);
          dec_mask = SLV_MASK[i*AW +: AW];
        end
      end
    end
  end

  // FSM next state and next values of every registered output.
  always_comb begin
    state_nxt = state_q;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    req_nxt   = '0;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    wstrb_nxt = wstrb_q;
    we_nxt    = we_q;
    sel_nxt   = sel_q;
    timer_nxt = timer_q;
    pend_nxt  = 1'b0;
    err_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          ack_nxt  = 1'b1;
          err_nxt  = 1'b1;
          err_done = 1'b1;
        end else if (cpu_req && !ack_q) begin
          if (dec_hit) begin
            req_nxt[dec_idx] = 1'b1;
            addr_nxt  = cpu_addr & dec_mask;
            wdata_nxt = cpu_wdata;
            wstrb_nxt = cpu_wstrb;
            we_nxt    = cpu_we;
            sel_nxt   = dec_idx;
            timer_nxt = '0;
            state_nxt = WAIT;
          end else begin
            pend_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        // An ack in the same cycle as the final timer value still completes normally.
        if (sel_ack) begin
          ack_nxt   = 1'b1;
          rdata_nxt = sel_rdata;
          state_nxt = IDLE;
        end else if (timer_q == TMO) begin
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
          err_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer_q + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating error-completion counter.
  always_comb begin
    errcnt_nxt = errcnt_q;
    if (err_done && (errcnt_q != 8'hFF)) begin
      errcnt_nxt = errcnt_q + 8'd1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      req_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      timer_q  <= '0;
      pend_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      rdata_q  <= rdata_nxt;
      req_q    <= req_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      wstrb_q  <= wstrb_nxt;
      we_q     <= we_nxt;
      sel_q    <= sel_nxt;
      timer_q  <= timer_nxt;
      pend_q   <= pend_nxt;
      errcnt_q <= errcnt_nxt;
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign slv_req   = req_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_wstrb = wstrb_q;
  assign slv_we    = we_q;
  assign err_count = errcnt_q;

endmodule

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 Parameter NSLV, default 4: number of slave channels, 1..8.
REQ-002 Parameter AW, default 24: CPU byte-address width.
REQ-003 Parameter DW, default 16: data width; SW = DW/8 strobe bits.
REQ-004 Parameter SLV_BASE, default 0: NSLV*AW flattened base addresses, channel i in bits [i*AW +: AW].
REQ-005 Parameter SLV_MASK, default 0: NSLV*AW flattened masks; 1 bits are offset bits, 0 bits are compared against the base.
REQ-006 Parameter BOOT_SLV, default 0: channel that serves the boot overlay.
REQ-007 Parameter BOOT_LIMIT, default 8: overlay covers addresses below this value.
REQ-008 Parameter TIMEOUT, default 255: maximum wait in cycles for a slave ack, 1..65535.
REQ-009 clk  in  1  sole clock; all logic on its rising edge.
REQ-010 rstn  in  1  reset; synchronous and active-low.
REQ-011 cpu_req, cpu_we  in  1 each  request level; write enable.
REQ-012 cpu_addr  in  AW; cpu_wdata  in  DW; cpu_wstrb  in  SW.
REQ-013 cpu_ack, cpu_err  out  1 each  registered one-cycle completion and error flag.
REQ-014 cpu_rdata  out  DW  registered read data.
REQ-015 bootup  in  1  boot-overlay enable.
REQ-016 slv_req  out  NSLV  one-hot, one-cycle request pulse.
REQ-017 slv_addr  out  AW  latched cpu_addr AND slave mask (offset only).
REQ-018 slv_wdata  out  DW; slv_wstrb  out  SW; slv_we  out  1: latched copies of the CPU fields.
REQ-019 slv_ack  in  NSLV; slv_rdata  in  NSLV*DW flattened.
REQ-020 err_count  out  8  saturating count of error completions.

Function
REQ-021 FSM states IDLE and WAIT; reset enters IDLE.
REQ-022 IDLE accepts a request when cpu_req=1 and cpu_ack=0; the ack cycle never re-accepts the same request.
REQ-023 Decode on acceptance, in priority order:
- (a) bootup=1 and cpu_addr<BOOT_LIMIT: route to BOOT_SLV.
- (b) bootup=0 and cpu_addr<BOOT_LIMIT: error.
- (c) lowest index i with (cpu_addr & ~mask_i) == (base_i & ~mask_i).
- (d) no match: error.
REQ-024 Routed request: on the same edge pulse slv_req[i] for one cycle, latch slv_addr/wdata/wstrb/we and channel index, clear the timer, enter WAIT.
REQ-025 Error decode: next cycle cpu_ack=1, cpu_err=1, cpu_rdata=0; remain in IDLE.
REQ-026 WAIT with slv_ack[sel]=1: next cycle cpu_ack=1, cpu_err=0, cpu_rdata=slv_rdata[sel]; return to IDLE.
REQ-027 WAIT: timer increments each cycle without ack; when timer==TIMEOUT and no ack, next cycle cpu_ack=1, cpu_err=1, cpu_rdata=0; return to IDLE.
REQ-028 Ack arriving in the same cycle the timer reaches TIMEOUT wins; completes normally.
REQ-029 slv_ack on unselected channels, or any slv_ack in IDLE, is ignored; a late ack after timeout is dropped.
REQ-030 cpu_req changes during WAIT are ignored; latched fields hold until return to IDLE.
REQ-031 Each error completion increments err_count; it saturates at 255.
REQ-032 cpu_ack, cpu_err and slv_req are never high for more than one consecutive cycle per transaction.

Reset
REQ-033 rstn=0 at a clock edge forces IDLE, cpu_ack=0, cpu_err=0, cpu_rdata=0, slv_req=0, slv_addr/wdata/wstrb/we=0, timer=0 and err_count=0.
REQ-034 Reset during WAIT abandons the transaction with no cpu_ack; a subsequent slv_ack is ignored.

Verification
REQ-035 bootup=1, read 0x000004, BOOT_SLV acks after 3 cycles with rdata 0x1234 -> slv_req[BOOT_SLV] pulse, slv_addr per mask, cpu_ack one cycle after slv_ack, rdata 0x1234, err=0.
REQ-036 bootup=0, read 0x000002 -> no slv_req, cpu_ack=1 and cpu_err=1 on the second edge after acceptance, err_count=1.
REQ-037 Overlapping regions on ch1 and ch2 matching 0x040010 -> only slv_req[1] pulses.
REQ-038 Selected slave never acks, TIMEOUT=255 -> cpu_ack and cpu_err exactly 257 edges after acceptance; a late slv_ack is ignored.
REQ-039 256 unmapped accesses -> err_count=255 and held there.
REQ-040 rstn=0 for one cycle during WAIT, then slave acks -> no cpu_ack and all outputs at reset values; the next request decodes normally.
